axi_slave_arbiter: RTL and testbench
====================================

# axi_slave_arbiter

Round-robin ownership arbiter for one AXI slave port of the interconnect. Each slave-side address channel (AR or AW) gets one instance. Requests are the per-master AxVALIDs already routed by the address decoder. The block grants one master and holds that grant through the whole transaction, releasing it on the last response handshake (RLAST beat for reads, B handshake for writes). Its pointer drives the slave-side address mux and the ID-extension bits.

## Interface
- REQ_CNT, 2: number of requesting masters.
- PTR_BITS, $clog2(REQ_CNT): width of the grant pointer.
- TIMEOUT_CYCLES, 1024: response watchdog limit; used only when AXI_ARB_TIMEOUT_EN is defined.

- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- req_valid  in  REQ_CNT  per-master AxVALID targeting this slave.
- addr_ready  in  1  slave AxREADY.
- resp_valid  in  1  slave RVALID / BVALID.
- resp_ready  in  1  RREADY / BREADY from the owning master.
- resp_last  in  1  RLAST; tie to 1 for the write/B channel.
- grant_ptr  out  PTR_BITS  index of the current owner.
- addr_en  out  1  mux forwards the owner's AxVALID/AxREADY; when 0, the slave sees VALID=0 and all masters see READY=0.
- owner_valid  out  1  a transaction is owned (ADDR or DATA state); enables response routing.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from (last_ptr+1) mod REQ_CNT, with wrap-around.
  - Register the pick into grant_ptr and go to ADDR.
  - If no bits are set, stay in IDLE and hold grant_ptr unchanged.
- ADDR:
  - addr_en=1.
  - On addr_ready && req_valid[grant_ptr], go to DATA.
  - The owner dropping VALID is an AXI violation; the FSM stays in ADDR.
  - Requests from non-owners are ignored.
- DATA:
  - addr_en=0 and owner_valid=1.
  - On resp_valid && resp_ready && resp_last, go to IDLE and set last_ptr <= grant_ptr.
  - Non-last beats keep the FSM in DATA.
- Only one outstanding transaction per slave exists at a time.
- last_ptr resets to REQ_CNT-1, so master 0 wins the first arbitration.

## Timing
- Reset values: state=IDLE, grant_ptr=0, last_ptr=REQ_CNT-1, addr_en=0, owner_valid=0, timeout_err=0, watchdog counter=0.
- Reset takes effect immediately (asynchronous), including in mid-burst.
- Request sampled in IDLE at cycle N gives addr_en=1 at cycle N+1 (one-cycle grant latency).
- Address handshake at cycle N gives addr_en=0 at cycle N+1.
- Final response handshake at cycle N gives owner_valid=0 at cycle N+1.
- A new request pending at completion still passes through IDLE at N+1, with the next grant at N+2. This mandatory one-cycle bubble keeps the mux from switching mid-beat.
- grant_ptr is stable for the whole ADDR and DATA period. It changes only on the IDLE→ADDR edge.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration
- AXI_ARB_TIMEOUT_EN defined:
  - A counter runs in DATA and clears on every resp_valid && resp_ready beat and on leaving DATA.
  - When the counter reaches TIMEOUT_CYCLES-1 with no beat, the FSM goes to IDLE and last_ptr <= grant_ptr.
  - timeout_err=1 for exactly that cycle.
  - A completing handshake in the same cycle takes precedence: normal release, no error.
- AXI_ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout_err is tied to 0.
  - DATA is held indefinitely until the last handshake.

## Structure
- Shared AXI package holds:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE=0, ARB_ADDR=1, ARB_DATA=2};
  - the constant AXI_ARB_TIMEOUT_DEFAULT=1024;
  - the pointer type sized by PTR_BITS, shared with the ID-extension logic.
- One sub-module, rr_pick: a combinational round-robin priority selector.
  - Inputs: req vector and start index.
  - Outputs: pick index and pick_valid.

## Test plan
- Reset: pulse ARESETn low mid-cycle → all outputs 0 immediately. The first request with req_valid=2'b11 grants grant_ptr=0.
- Single read from master 0: req_valid=2'b01 at cycle 0 → addr_en=1 with grant_ptr=0 at cycle 1. addr_ready at cycle 3 → DATA at cycle 4. Four beats with resp_last on the 4th at cycle 8 → owner_valid=0 at cycle 9.
- Fairness: req_valid held at 2'b11 with single-beat transactions → grant sequence 0,1,0,1, each grant separated by one IDLE cycle.
- Contention during ownership: master 1 asserts while master 0 is in DATA → grant_ptr is never 1 and addr_en=0 until master 0's last beat. Master 1 is granted two cycles after that beat.
- Watchdog with AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no beats for 16 cycles in DATA → one-cycle timeout_err pulse, then IDLE. A beat at cycle 10 restarts the count. With the macro undefined, the block is still in DATA after 100 cycles and timeout_err=0.
- Non-last beats: resp_valid && resp_ready with resp_last=0 → the FSM stays in DATA and grant_ptr is unchanged.

Source files
------------

// File: rtl/axi_slave_arbiter_pkg.sv
// rtl/axi_slave_arbiter_pkg.sv - shared types and constants for the AXI slave-port arbiter
package axi_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam int AXI_ARB_TIMEOUT_DEFAULT = 1024;
    localparam int AXI_ARB_REQ_CNT_DEFAULT = 2;
    localparam int AXI_ARB_PTR_BITS        = $clog2(AXI_ARB_REQ_CNT_DEFAULT);

    // Owner index, also consumed by the ID-extension logic of the interconnect
    typedef logic [AXI_ARB_PTR_BITS-1:0] arb_ptr_t;

endpackage

// File: rtl/axi_slave_arbiter_rr_pick.sv
// rtl/axi_slave_arbiter_rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
    parameter int REQ_CNT  = 2,
    parameter int PTR_BITS = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0]  req_i,
    input  logic [PTR_BITS-1:0] start_i,
    output logic [PTR_BITS-1:0] pick_o,
    output logic                pick_valid_o
);

    // Scan offsets from farthest to nearest so the nearest set bit from start_i wins
    always_comb begin
        int                idx;
        logic [PTR_BITS-1:0] idx_p;
        pick_o       = '0;
        pick_valid_o = 1'b0;
        for (int i = REQ_CNT - 1; i >= 0; i--) begin
            idx   = (int'(start_i) + i) % REQ_CNT;
            idx_p = PTR_BITS'(idx);
            if (req_i[idx_p]) begin
                pick_o       = idx_p;
                pick_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_slave_arbiter.sv
// rtl/axi_slave_arbiter.sv - round-robin ownership arbiter for one AXI slave address channel (optional watchdog: AXI_ARB_TIMEOUT_EN)
module axi_slave_arbiter
    import axi_slave_arbiter_pkg::*;
#(
    parameter int REQ_CNT        = 2,
    parameter int PTR_BITS       = $clog2(REQ_CNT),
    parameter int TIMEOUT_CYCLES = AXI_ARB_TIMEOUT_DEFAULT
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [REQ_CNT-1:0]  req_valid,
    input  logic                addr_ready,
    input  logic                resp_valid,
    input  logic                resp_ready,
    input  logic                resp_last,
    output logic [PTR_BITS-1:0] grant_ptr,
    output logic                addr_en,
    output logic                owner_valid,
    output logic                timeout_err
);

    arb_state_e          state_q, state_d;
    logic [PTR_BITS-1:0] grant_q, grant_d;
    logic [PTR_BITS-1:0] last_q,  last_d;
    logic [PTR_BITS-1:0] start_ptr;
    logic [PTR_BITS-1:0] pick;
    logic                pick_valid;
    logic                beat;

    assign beat      = resp_valid & resp_ready;
    assign start_ptr = (last_q == PTR_BITS'(REQ_CNT - 1)) ? '0 : last_q + PTR_BITS'(1);

    rr_pick #(
        .REQ_CNT  (REQ_CNT),
        .PTR_BITS (PTR_BITS)
    ) u_rr_pick (
        .req_i        (req_valid),
        .start_i      (start_ptr),
        .pick_o       (pick),
        .pick_valid_o (pick_valid)
    );

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    // Next-state: grant only from IDLE, hold the owner through address and response phases
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef AXI_ARB_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // A dropped owner VALID is a protocol violation; keep waiting rather than re-arbitrate
                if (addr_ready && req_valid[grant_q]) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (beat && resp_last) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
`ifdef AXI_ARB_TIMEOUT_EN
                else if (beat) begin
                    cnt_d = '0;
                end else if (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, owner pointer and round-robin history registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= PTR_BITS'(REQ_CNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    // Response watchdog counter and its single-cycle error flag
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant_ptr   = grant_q;
    assign addr_en     = (state_q == ARB_ADDR);
    assign owner_valid = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// tb/tb_axi_slave_arbiter.sv - self-checking bench for axi_slave_arbiter
module tb_axi_slave_arbiter;

    localparam int REQ_CNT = 2;
    localparam int PB      = 1;

    logic          ACLK;
    logic          ARESETn;
    logic [1:0]    req_valid;
    logic          addr_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_last;
    logic [PB-1:0] grant_ptr;
    logic          addr_en;
    logic          owner_valid;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PB-1:0] exp_q[$];

    axi_slave_arbiter #(
        .REQ_CNT        (REQ_CNT),
        .PTR_BITS       (PB),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req_valid   (req_valid),
        .addr_ready  (addr_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_last   (resp_last),
        .grant_ptr   (grant_ptr),
        .addr_en     (addr_en),
        .owner_valid (owner_valid),
        .timeout_err (timeout_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = 2'b00;
        addr_ready = 1'b0;
        resp_valid = 1'b0;
        resp_ready = 1'b0;
        resp_last  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_grant(input string name, input int budget);
        int            n;
        logic [PB-1:0] e;
        n = 0;
        while (addr_en !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (addr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL %s grant_wait addr_en=%b required 1 after %0d cycles", name, addr_en, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_grant grant_ptr=%0d required no grant", name, grant_ptr);
        end else begin
            e = exp_q.pop_front();
            if (grant_ptr !== e) begin
                n_fail++;
                $display("FAIL %s grant_ptr=%0d required %0d", name, grant_ptr, e);
            end
        end
    endtask

    task automatic addr_handshake();
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
    endtask

    task automatic last_beat();
        resp_valid = 1'b1;
        resp_ready = 1'b1;
        resp_last  = 1'b1;
        tick();
        resp_valid = 1'b0;
        resp_ready = 1'b0;
        resp_last  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({addr_en, owner_valid, timeout_err, grant_ptr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state addr_en=%b owner_valid=%b timeout_err=%b grant_ptr=%0d required all 0",
                     addr_en, owner_valid, timeout_err, grant_ptr);
        end
        req_valid = 2'b10;
        exp_q.push_back(1'b1);
        tick();
        wait_grant("reset_pre_grant", 0);
        addr_handshake();
        req_valid = 2'b00;
        n_checks++;
        if (owner_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_data owner_valid=%b required 1", owner_valid);
        end
        #2;
        ARESETn = 1'b0;
        #1;
        n_checks++;
        if ({addr_en, owner_valid, timeout_err, grant_ptr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async addr_en=%b owner_valid=%b timeout_err=%b grant_ptr=%0d required all 0",
                     addr_en, owner_valid, timeout_err, grant_ptr);
        end
        tick();
        ARESETn   = 1'b1;
        req_valid = 2'b11;
        exp_q.push_back(1'b0);
        tick();
        wait_grant("reset_first_grant", 0);
        req_valid = 2'b00;
        addr_handshake();
        last_beat();
    endtask

    task automatic test_single_read();
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back(1'b0);
        tick();
        wait_grant("single_grant_c1", 0);
        for (int c = 2; c <= 3; c++) begin
            tick();
            n_checks++;
            if (addr_en !== 1'b1 || grant_ptr !== 1'b0) begin
                n_fail++;
                $display("FAIL single_addr_hold c%0d addr_en=%b grant_ptr=%0d required 1 0", c, addr_en, grant_ptr);
            end
        end
        addr_handshake();
        req_valid = 2'b00;
        n_checks++;
        if (addr_en !== 1'b0 || owner_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data_c4 addr_en=%b owner_valid=%b required 0 1", addr_en, owner_valid);
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            resp_valid = 1'b1;
            resp_ready = 1'b1;
            resp_last  = 1'b0;
            tick();
            n_checks++;
            if (owner_valid !== 1'b1 || addr_en !== 1'b0 || grant_ptr !== 1'b0) begin
                n_fail++;
                $display("FAIL nonlast_beat%0d owner_valid=%b addr_en=%b grant_ptr=%0d required 1 0 0",
                         b, owner_valid, addr_en, grant_ptr);
            end
        end
        last_beat();
        n_checks++;
        if (owner_valid !== 1'b0 || addr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release_c9 owner_valid=%b addr_en=%b required 0 0", owner_valid, addr_en);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 2'b11;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        tick();
        for (int t = 0; t < 4; t++) begin
            wait_grant($sformatf("fair_grant%0d", t), 0);
            addr_handshake();
            last_beat();
            n_checks++;
            if (owner_valid !== 1'b0 || addr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_bubble%0d owner_valid=%b addr_en=%b required 0 0", t, owner_valid, addr_en);
            end
            if (t == 3) req_valid = 2'b00;
            tick();
        end
        n_checks++;
        if (addr_en !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fair_drain addr_en=%b pending=%0d required 0 0", addr_en, exp_q.size());
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back(1'b0);
        tick();
        wait_grant("cont_grant0", 0);
        addr_handshake();
        req_valid = 2'b10;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (grant_ptr !== 1'b0 || addr_en !== 1'b0 || owner_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL cont_hold c%0d grant_ptr=%0d addr_en=%b owner_valid=%b required 0 0 1",
                         c, grant_ptr, addr_en, owner_valid);
            end
        end
        last_beat();
        n_checks++;
        if (addr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_bubble addr_en=%b required 0", addr_en);
        end
        exp_q.push_back(1'b1);
        tick();
        wait_grant("cont_grant1", 0);
        req_valid = 2'b00;
        addr_handshake();
        last_beat();
    endtask

    task automatic test_watchdog();
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back(1'b0);
        tick();
        wait_grant("wd_grant", 0);
        addr_handshake();
        req_valid = 2'b00;
`ifdef AXI_ARB_TIMEOUT_EN
        for (int k = 1; k <= 28; k++) begin
            resp_valid = (k - 1 == 10);
            resp_ready = (k - 1 == 10);
            resp_last  = 1'b0;
            tick();
            n_checks++;
            if (timeout_err !== (k == 27) || owner_valid !== (k < 27)) begin
                n_fail++;
                $display("FAIL wd_restart k%0d timeout_err=%b owner_valid=%b required %b %b",
                         k, timeout_err, owner_valid, (k == 27), (k < 27));
            end
        end
        clear_inputs();
        req_valid = 2'b01;
        exp_q.push_back(1'b0);
        tick();
        wait_grant("wd_grant2", 0);
        addr_handshake();
        req_valid = 2'b00;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_checks++;
            if (timeout_err !== (k == 16) || owner_valid !== (k < 16)) begin
                n_fail++;
                $display("FAIL wd_plain k%0d timeout_err=%b owner_valid=%b required %b %b",
                         k, timeout_err, owner_valid, (k == 16), (k < 16));
            end
        end
`else
        for (int k = 1; k <= 100; k++) begin
            tick();
            n_checks++;
            if (timeout_err !== 1'b0 || owner_valid !== 1'b1 || grant_ptr !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_disabled k%0d timeout_err=%b owner_valid=%b grant_ptr=%0d required 0 1 0",
                         k, timeout_err, owner_valid, grant_ptr);
            end
        end
        last_beat();
        n_checks++;
        if (owner_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_disabled_release owner_valid=%b required 0", owner_valid);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        ARESETn = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_contention();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
